// File: rtl/tc_stack_arbiter.sv
// tc_stack_arbiter: one LIFO array shared by two clients through a
// registered request/acknowledge handshake with round-robin priority.
module tc_stack_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    output logic [WIDTH-1:0] dout0,
    output logic             err0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    output logic [WIDTH-1:0] dout1,
    output logic             err1,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] top
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      count_q, count_d;
    logic             prio_q, prio_d;    // 0: client 0 wins a tie, 1: client 1 wins
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;

    logic [AW:0]      count_m1;
    logic [WIDTH-1:0] rd_data;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    assign count_m1 = count_q - 1'b1;
    assign rd_data  = mem[count_m1[AW-1:0]];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign top      = empty ? '0 : rd_data;
    assign count    = count_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign dout0    = dout0_q;
    assign dout1    = dout1_q;

    // Arbitrate between eligible clients and compute the granted stack operation.
    always_comb begin
        logic elig0, elig1, g0, g1, gop, rej;
        logic [WIDTH-1:0] pop_data;
        count_d  = count_q;
        prio_d   = prio_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        dout0_d  = '0;
        dout1_d  = '0;
        mem_we   = 1'b0;
        mem_wa   = count_q[AW-1:0];
        mem_wd   = din0;
        g0       = 1'b0;
        g1       = 1'b0;
        gop      = 1'b0;
        rej      = 1'b0;
        pop_data = '0;
        // A client acked this cycle is presenting a fresh request and must wait one cycle.
        elig0    = req0 && !ack0_q;
        elig1    = req1 && !ack1_q;
        if (!flush) begin
            g0 = elig0 && (!elig1 || !prio_q);
            g1 = elig1 && (!elig0 || prio_q);
        end
        if (g0 || g1) begin
            prio_d = g0;
            gop    = g0 ? op0 : op1;
            mem_wd = g0 ? din0 : din1;
            if (!gop) begin
                if (full) begin
                    rej = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (empty) begin
                    rej = 1'b1;
                end else begin
                    pop_data = rd_data;
                    count_d  = count_m1;
                end
            end
            ack0_d  = g0;
            ack1_d  = g1;
            err0_d  = g0 && rej;
            err1_d  = g1 && rej;
            dout0_d = g0 ? pop_data : '0;
            dout1_d = g1 ? pop_data : '0;
        end
        if (flush) begin
            count_d = '0;
        end
    end

    // Control and handshake registers; reset overrides flush and requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            prio_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            count_q <= count_d;
            prio_q  <= prio_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    // Stack storage; contents are never cleared since top is gated when empty.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_tc_stack_arbiter.sv
// Directed testbench for tc_stack_arbiter (instantiated with a 4-entry stack).
module tb_tc_stack_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             req0, op0, req1, op1;
    logic [WIDTH-1:0] din0, din1;
    logic             ack0, ack1, err0, err1;
    logic [WIDTH-1:0] dout0, dout1, top;
    logic [AW:0]      count;
    logic             empty, full;

    int nvec = 0;
    int nmis = 0;

    tc_stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0(req0), .op0(op0), .din0(din0), .ack0(ack0), .dout0(dout0), .err0(err0),
        .req1(req1), .op1(op1), .din1(din1), .ack1(ack1), .dout1(dout1), .err1(err1),
        .count(count), .empty(empty), .full(full), .top(top)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0;
        req0 = 1'b0; op0 = 1'b0; din0 = '0;
        req1 = 1'b0; op1 = 1'b0; din1 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (count !== 3'd0) begin nmis++; $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (empty !== 1'b1 || full !== 1'b0) begin nmis++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", empty, full); end
        nvec++; if (top !== 8'h00) begin nmis++; $display("FAIL reset_top got %h want 00", top); end
        nvec++; if ({ack0, ack1, err0, err1} !== 4'b0000) begin nmis++; $display("FAIL reset_hs got %b want 0000", {ack0, ack1, err0, err1}); end
        nvec++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin nmis++; $display("FAIL reset_dout got %h/%h want 00/00", dout0, dout1); end
    endtask

    task automatic test_push_held();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        do_reset();
        req0 = 1'b1; op0 = 1'b0; din0 = vals[0];
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++;
            if (ack0 !== ((i % 2) == 0)) begin nmis++; $display("FAIL push_held_ack%0d got %b want %b", i, ack0, (i % 2) == 0); end
            if (i % 2 == 0) begin
                if (i / 2 < 2) din0 = vals[i/2+1];
                else req0 = 1'b0;
            end
        end
        nvec++; if (count !== 3'd3) begin nmis++; $display("FAIL push_held_count got %0d want 3", count); end
        nvec++; if (top !== 8'h33) begin nmis++; $display("FAIL push_held_top got %h want 33", top); end
        req1 = 1'b1; op1 = 1'b1;
        step();
        req1 = 1'b0;
        nvec++; if (ack1 !== 1'b1 || err1 !== 1'b0 || dout1 !== 8'h33) begin nmis++; $display("FAIL pop1 got ack=%b err=%b dout=%h want 1 0 33", ack1, err1, dout1); end
        nvec++; if (count !== 3'd2 || top !== 8'h22) begin nmis++; $display("FAIL pop1_count got %0d top %h want 2 22", count, top); end
        step();
        nvec++; if (ack1 !== 1'b0 || dout1 !== 8'h00) begin nmis++; $display("FAIL pop1_idle got ack=%b dout=%h want 0 00", ack1, dout1); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_pop [4];
        exp_pop[0] = 8'hB3; exp_pop[1] = 8'hA2; exp_pop[2] = 8'hB1; exp_pop[3] = 8'hA0;
        do_reset();
        req0 = 1'b1; op0 = 1'b0; din0 = 8'hA0;
        req1 = 1'b1; op1 = 1'b0; din1 = 8'hB1;
        step();
        nvec++; if ({ack0, ack1} !== 2'b10) begin nmis++; $display("FAIL rr_g0 got %b want 10", {ack0, ack1}); end
        din0 = 8'hA2;
        step();
        nvec++; if ({ack0, ack1} !== 2'b01) begin nmis++; $display("FAIL rr_g1 got %b want 01", {ack0, ack1}); end
        din1 = 8'hB3;
        step();
        nvec++; if ({ack0, ack1} !== 2'b10) begin nmis++; $display("FAIL rr_g2 got %b want 10", {ack0, ack1}); end
        req0 = 1'b0;
        step();
        nvec++; if ({ack0, ack1} !== 2'b01) begin nmis++; $display("FAIL rr_g3 got %b want 01", {ack0, ack1}); end
        req1 = 1'b0;
        nvec++; if (count !== 3'd4 || full !== 1'b1 || top !== 8'hB3) begin nmis++; $display("FAIL rr_fill got cnt=%0d full=%b top=%h want 4 1 b3", count, full, top); end
        req0 = 1'b1; op0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            nvec++;
            if (i % 2 == 0) begin
                if (ack0 !== 1'b1 || err0 !== 1'b0 || dout0 !== exp_pop[i/2]) begin
                    nmis++; $display("FAIL rr_pop%0d got ack=%b err=%b dout=%h want 1 0 %h", i/2, ack0, err0, dout0, exp_pop[i/2]);
                end
                if (i == 6) req0 = 1'b0;
            end else if (ack0 !== 1'b0 || dout0 !== 8'h00) begin
                nmis++; $display("FAIL rr_gap%0d got ack=%b dout=%h want 0 00", i, ack0, dout0);
            end
        end
        nvec++; if (count !== 3'd0 || empty !== 1'b1) begin nmis++; $display("FAIL rr_drain got cnt=%0d empty=%b want 0 1", count, empty); end
    endtask

    task automatic test_full();
        do_reset();
        req0 = 1'b1; op0 = 1'b0; din0 = 8'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i % 2 == 0) begin
                nvec++;
                if (ack0 !== 1'b1 || err0 !== (i == 8)) begin
                    nmis++; $display("FAIL full_push%0d got ack=%b err=%b want 1 %b", i/2, ack0, err0, i == 8);
                end
                if (i < 8) din0 = 8'(i/2 + 2);
                else req0 = 1'b0;
            end
        end
        nvec++; if (count !== 3'd4 || full !== 1'b1 || top !== 8'd4) begin nmis++; $display("FAIL full_state got cnt=%0d full=%b top=%h want 4 1 04", count, full, top); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        req1 = 1'b1; op1 = 1'b1;
        step();
        req1 = 1'b0;
        nvec++; if (ack1 !== 1'b1 || err1 !== 1'b1 || dout1 !== 8'h00) begin nmis++; $display("FAIL pop_empty got ack=%b err=%b dout=%h want 1 1 00", ack1, err1, dout1); end
        nvec++; if (count !== 3'd0 || empty !== 1'b1) begin nmis++; $display("FAIL pop_empty_state got cnt=%0d empty=%b want 0 1", count, empty); end
        step();
        nvec++; if (ack1 !== 1'b0 || err1 !== 1'b0) begin nmis++; $display("FAIL pop_empty_idle got ack=%b err=%b want 0 0", ack1, err1); end
    endtask

    task automatic test_flush();
        do_reset();
        req1 = 1'b1; op1 = 1'b0; din1 = 8'h07;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 0) begin
                if (i < 4) din1 = 8'(8'h08 + i/2);
                else req1 = 1'b0;
            end
        end
        nvec++; if (count !== 3'd3 || top !== 8'h09) begin nmis++; $display("FAIL flush_fill got cnt=%0d top=%h want 3 09", count, top); end
        req0 = 1'b1; op0 = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        nvec++; if (ack0 !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin nmis++; $display("FAIL flush_clear got ack=%b cnt=%0d empty=%b want 0 0 1", ack0, count, empty); end
        step();
        req0 = 1'b0;
        nvec++; if (ack0 !== 1'b1 || err0 !== 1'b1 || dout0 !== 8'h00) begin nmis++; $display("FAIL flush_pop got ack=%b err=%b dout=%h want 1 1 00", ack0, err0, dout0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1; op0 = 1'b0; din0 = 8'h10;
        step();
        req0 = 1'b0;
        nvec++; if (ack0 !== 1'b1 || count !== 3'd1) begin nmis++; $display("FAIL rstmid_pre got ack=%b cnt=%0d want 1 1", ack0, count); end
        req1 = 1'b1; op1 = 1'b0; din1 = 8'h5A; rst = 1'b1;
        step();
        rst = 1'b0; req1 = 1'b0;
        nvec++; if (ack1 !== 1'b0 || count !== 3'd0 || top !== 8'h00) begin nmis++; $display("FAIL rstmid got ack1=%b cnt=%0d top=%h want 0 0 00", ack1, count, top); end
        req0 = 1'b1; op0 = 1'b0; din0 = 8'hC0;
        req1 = 1'b1; op1 = 1'b0; din1 = 8'hC1;
        step();
        req0 = 1'b0; req1 = 1'b0;
        nvec++; if ({ack0, ack1} !== 2'b10 || top !== 8'hC0) begin nmis++; $display("FAIL rstmid_prio got acks=%b top=%h want 10 c0", {ack0, ack1}, top); end
        step();
    endtask

    initial begin
        test_reset();
        test_push_held();
        test_round_robin();
        test_full();
        test_pop_empty();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/tc_stack_arbiter.md
Name: tc_stack_arbiter

Overview:
- Owns one LIFO storage array and shares it between two requesters (client 0 and client 1) through a registered request/acknowledge handshake.
- Grants at most one push or pop per cycle, alternating priority round-robin.
- Reports occupancy, full/empty and rejected operations.
- Sits between two producer/consumer units that would otherwise need private stacks.

Parameters:
- WIDTH, 8, data width of each stack entry.
- DEPTH, 256, number of entries.
- AW, 8, pointer width, equal to log2(DEPTH). DEPTH must be a power of two.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous stack clear; empties the stack without resetting arbitration.
- req0  input  1  client 0 request; held until ack0.
- op0  input  1  client 0 operation: 0 = push, 1 = pop.
- din0  input  WIDTH  client 0 push data.
- ack0  output  1  one-cycle pulse: client 0 operation completed or rejected.
- dout0  output  WIDTH  client 0 pop data; valid while ack0 = 1.
- err0  output  1  asserted with ack0 when the operation was rejected.
- req1, op1, din1, ack1, dout1, err1: as client 0, for client 1.
- count  output  AW+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- top  output  WIDTH  mem[count-1] when not empty, else 0.

Behaviour:
- Reset (rst = 1 at an edge):
  - count = 0; ack0/1, err0/1, dout0/1 = 0; priority pointer = client 0.
  - Memory contents are not cleared. They are unobservable because top is gated to 0 when empty.
  - rst overrides flush and all requests.
- Eligibility at edge N:
  - Client k is eligible if reqk = 1 and ackk is not high in cycle N, i.e. k was not granted at edge N-1.
  - A client is therefore served at most every other cycle.
  - A client that keeps req high after seeing ack presents a new request, which can be granted from edge N+2.
- Arbitration:
  - Only one eligible client: that client is granted.
  - Both eligible: the client named by the priority pointer is granted.
  - After any grant to client k, the pointer moves to the other client.
  - No grant: the pointer is unchanged.
- Granted push:
  - Not full: mem[count] <= din, count <= count+1, err = 0.
  - Full: no write, count unchanged, err = 1.
- Granted pop:
  - Not empty: dout <= mem[count-1], count <= count-1, err = 0.
  - Empty: dout <= 0, count unchanged, err = 1.
- Latency: an operation granted at edge N shows ackk, errk and doutk during cycle N+1 (one cycle), and count/top updated in cycle N+1.
- Outputs outside an ack cycle: ack and err are 0. dout holds 0 in every cycle where its ack is 0.
- Flush at an edge (rst = 0):
  - count <= 0; no grant at that edge; no acks in the next cycle; the pointer is unchanged.
  - Pending requests stay pending and are arbitrated after flush deasserts.
- Validity of held signals: op and din must stay stable while req is held; they are sampled only at the grant edge.
- Arithmetic: count never wraps. Overflow and underflow are prevented by the rejection rules.
- Registered vs combinational: empty, full and top are combinational from count and mem. All handshake outputs are registered.

Test Plan:
- Reset, then client 0 pushes 0x11, 0x22, 0x33 back-to-back with req held:
  - acks occur every other cycle;
  - count = 3, top = 0x33;
  - a client 1 pop returns dout1 = 0x33 with ack1, err1 = 0, then count = 2.
- Both clients request in the same cycle from reset (client 0 push 0xA0, client 1 push 0xB1), held continuously:
  - grants alternate 0,1,0,1, one per cycle;
  - a subsequent pop sequence returns the pushed data in reverse grant order.
- DEPTH = 4: five pushes 1,2,3,4,5:
  - the fifth gets ack with err = 1;
  - count stays 4, full = 1, top = 4.
- Pop when empty after reset: ack1 = 1, err1 = 1, dout1 = 0, count = 0, empty = 1.
- Stack holding 3 entries:
  - flush asserted in the same cycle as a pending client 0 pop gives count = 0 and no ack that cycle;
  - the pop is then served after flush drops, returning err0 = 1.
- rst asserted while client 1 ack is due:
  - the next cycle shows ack1 = 0, count = 0, top = 0;
  - a following simultaneous request grants client 0 first.
